// File: rtl/safecrack_pkg.sv
// safecrack_pkg: state encoding and helper functions shared by the safecrack_pro_fsm lock.
package safecrack_pkg;

  // One-hot so each indicator decodes from a single state bit; PROGRAM is always enumerated.
  typedef enum logic [4:0] {
    ST_ENTRY    = 5'b00001,
    ST_ERROR    = 5'b00010,
    ST_UNLOCKED = 5'b00100,
    ST_LOCKOUT  = 5'b01000,
    ST_PROGRAM  = 5'b10000
  } state_t;

  // Progress mask with bits [idx:0] set; callers truncate to CODE_LEN bits.
  function automatic logic [63:0] therm(input int unsigned idx);
    logic [63:0] mask;
    mask = '0;
    for (int unsigned i = 0; i < 64; i++) begin
      if (i <= idx) mask[i] = 1'b1;
    end
    return mask;
  endfunction

  function automatic logic [63:0] sec_to_cycles(input logic [63:0] hz, input logic [63:0] sec);
    return hz * sec;
  endfunction

endpackage

// File: rtl/safecrack_btn_sync.sv
// safecrack_btn_sync: 2-FF synchroniser plus press-edge detector for W active-low buttons.
module safecrack_btn_sync #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic [W-1:0] raw_n_i,
  output logic [W-1:0] edge_o
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;
  logic [W-1:0] prev_q;
  logic [2:0]   arm_q;

  // NOTE: non-blocking assignments make the flops update together, so the chain really shifts by one stage per clock.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      meta_q <= '1;
      sync_q <= '1;
      prev_q <= '0;
      arm_q  <= '0;
    end else begin
      meta_q <= raw_n_i;
      sync_q <= meta_q;
      prev_q <= ~sync_q;
      arm_q  <= {arm_q[1:0], 1'b1};
    end
  end

  // Edges are held off until prev has seen a post-reset sample, so a button held through reset never fires.
  assign edge_o = arm_q[2] ? (~sync_q & ~prev_q) : '0;

endmodule

// File: rtl/safecrack_pro_fsm.sv
// safecrack_pro_fsm: combination lock with progress LEDs, fail counting, timed lockout and stored code.
// Define SAFECRACK_REPROGRAM_EN to add the prog_n_i port and the PROGRAM state.
module safecrack_pro_fsm
  import safecrack_pkg::*;
#(
  parameter int unsigned                           NUM_BTN      = 4,
  parameter int unsigned                           CODE_LEN     = 4,
  parameter logic [CODE_LEN*$clog2(NUM_BTN)-1:0]   DEFAULT_CODE = 8'hE4,
  parameter int unsigned                           CLK_HZ       = 50_000_000,
  parameter int unsigned                           ERR_SEC      = 3,
  parameter int unsigned                           OPEN_SEC     = 5,
  parameter int unsigned                           MAX_FAILS    = 3,
  parameter int unsigned                           LOCKOUT_SEC  = 30
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic [NUM_BTN-1:0]             btn_i,
`ifdef SAFECRACK_REPROGRAM_EN
  input  logic                           prog_n_i,
`endif
  output logic [CODE_LEN-1:0]            led_progress_o,
  output logic                           led_r_o,
  output logic                           led_lock_o,
  output logic [$clog2(MAX_FAILS+1)-1:0] fail_cnt_o
);

  localparam int unsigned DW = $clog2(NUM_BTN);
  localparam int unsigned IW = (CODE_LEN > 1) ? $clog2(CODE_LEN) : 1;
  localparam int unsigned FW = $clog2(MAX_FAILS + 1);

  localparam logic [63:0] ERR_CYC  = sec_to_cycles(64'(CLK_HZ), 64'(ERR_SEC));
  localparam logic [63:0] OPEN_CYC = sec_to_cycles(64'(CLK_HZ), 64'(OPEN_SEC));
  localparam logic [63:0] LOCK_CYC = sec_to_cycles(64'(CLK_HZ), 64'(LOCKOUT_SEC));
  localparam logic [63:0] MAX_EO   = (ERR_CYC > OPEN_CYC) ? ERR_CYC : OPEN_CYC;
  localparam logic [63:0] MAX_CYC  = (MAX_EO > LOCK_CYC) ? MAX_EO : LOCK_CYC;
  localparam int unsigned TW       = (MAX_CYC > 64'd1) ? $clog2(MAX_CYC) : 1;

  localparam logic [TW-1:0] ERR_LOAD  = TW'(ERR_CYC - 64'd1);
  localparam logic [TW-1:0] OPEN_LOAD = TW'(OPEN_CYC - 64'd1);
  localparam logic [TW-1:0] LOCK_LOAD = TW'(LOCK_CYC - 64'd1);

  state_t                 state_q, state_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic [FW-1:0]          fail_q, fail_d, fail_inc;
  logic [TW-1:0]          timer_q, timer_d;
  logic [NUM_BTN-1:0]     btn_edge;
  logic [DW-1:0]          press_val;
  logic                   press_any, press_one, last_digit, timer_done;
  logic [CODE_LEN*DW-1:0] code;

  safecrack_btn_sync #(.W(NUM_BTN)) u_btn_sync (
    .clk     (clk),
    .rstn    (rstn),
    .raw_n_i (btn_i),
    .edge_o  (btn_edge)
  );

`ifdef SAFECRACK_REPROGRAM_EN
  logic                   prog_edge;
  logic [CODE_LEN*DW-1:0] code_q, code_d, shadow_q, shadow_d;

  safecrack_btn_sync #(.W(1)) u_prog_sync (
    .clk     (clk),
    .rstn    (rstn),
    .raw_n_i (prog_n_i),
    .edge_o  (prog_edge)
  );

  assign code = code_q;
`else
  assign code = DEFAULT_CODE;
`endif

  always_comb begin
    press_val = '0;
    for (int unsigned i = 0; i < NUM_BTN; i++) begin
      if (btn_edge[i]) press_val = DW'(i);
    end
  end

  assign press_any  = |btn_edge;
  assign press_one  = $onehot(btn_edge);
  assign last_digit = (idx_q == IW'(CODE_LEN - 1));
  assign timer_done = (timer_q == '0);
  assign fail_inc   = fail_q + 1'b1;

  // NOTE: every next-state signal takes its hold value first, so no path through the case can infer a latch.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    fail_d  = fail_q;
    timer_d = timer_q;
`ifdef SAFECRACK_REPROGRAM_EN
    code_d   = code_q;
    shadow_d = shadow_q;
`endif
    case (state_q)
      ST_ENTRY: begin
        if (press_any) begin
          if (press_one && press_val == code[idx_q*DW +: DW]) begin
            if (last_digit) begin
              state_d = ST_UNLOCKED;
              idx_d   = '0;
              fail_d  = '0;
              timer_d = OPEN_LOAD;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end else begin
            idx_d  = '0;
            fail_d = fail_inc;
            if (fail_inc == FW'(MAX_FAILS)) begin
              state_d = ST_LOCKOUT;
              timer_d = LOCK_LOAD;
            end else begin
              state_d = ST_ERROR;
              timer_d = ERR_LOAD;
            end
          end
        end
      end
      ST_ERROR, ST_UNLOCKED, ST_LOCKOUT: begin
        if (timer_done) begin
          state_d = ST_ENTRY;
          idx_d   = '0;
          if (state_q == ST_LOCKOUT) fail_d = '0;
        end
`ifdef SAFECRACK_REPROGRAM_EN
        else if (state_q == ST_UNLOCKED && prog_edge) begin
          state_d = ST_PROGRAM;
          idx_d   = '0;
          timer_d = OPEN_LOAD;
        end
`endif
        else begin
          timer_d = timer_q - 1'b1;
        end
      end
`ifdef SAFECRACK_REPROGRAM_EN
      ST_PROGRAM: begin
        if (press_any) begin
          state_d = ST_ENTRY;
          idx_d   = '0;
          if (press_one) begin
            shadow_d[idx_q*DW +: DW] = press_val;
            if (last_digit) begin
              code_d = shadow_d;
            end else begin
              state_d = ST_PROGRAM;
              idx_d   = idx_q + 1'b1;
              timer_d = OPEN_LOAD;
            end
          end
        end else if (timer_done) begin
          state_d = ST_ENTRY;
          idx_d   = '0;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
`endif
      default: begin
        state_d = ST_ENTRY;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_ENTRY;
      idx_q   <= '0;
      fail_q  <= '0;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      fail_q  <= fail_d;
      timer_q <= timer_d;
    end
  end

`ifdef SAFECRACK_REPROGRAM_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) code_q <= DEFAULT_CODE;
    else       code_q <= code_d;
  end

  // NOTE: shadow_q has no reset; every digit is rewritten before it is ever copied into code_q.
  always_ff @(posedge clk) begin
    shadow_q <= shadow_d;
  end
`endif

  always_comb begin
    led_progress_o = '0;
    case (state_q)
      ST_ENTRY:    led_progress_o = CODE_LEN'(therm(32'(idx_q)));
      ST_UNLOCKED: led_progress_o = '1;
      ST_PROGRAM:  if (idx_q != '0) led_progress_o = CODE_LEN'(therm(32'(idx_q) - 32'd1));
      default:     led_progress_o = '0;
    endcase
  end

  assign led_r_o    = (state_q == ST_ERROR);
  assign led_lock_o = (state_q == ST_LOCKOUT);
  assign fail_cnt_o = fail_q;

endmodule

// File: tb/tb_safecrack_pro_fsm.sv
// tb_safecrack_pro_fsm: directed and random button traffic, scoreboarded against a behavioural lock model.
module tb_safecrack_pro_fsm;

  localparam int NUM_BTN     = 4;
  localparam int CODE_LEN    = 4;
  localparam int CLK_HZ      = 10;
  localparam int ERR_SEC     = 3;
  localparam int OPEN_SEC    = 5;
  localparam int MAX_FAILS   = 3;
  localparam int LOCKOUT_SEC = 30;
  localparam int FW          = $clog2(MAX_FAILS + 1);
  localparam logic [7:0] DEF_CODE = 8'hE4;

  logic                clk = 1'b0;
  logic                rstn;
  logic [NUM_BTN-1:0]  btn = '1;
  logic                prog_n = 1'b1;
  logic [CODE_LEN-1:0] led_progress;
  logic                led_r;
  logic                led_lock;
  logic [FW-1:0]       fail_cnt;

  always #5 clk = ~clk;

  safecrack_pro_fsm #(
    .NUM_BTN      (NUM_BTN),
    .CODE_LEN     (CODE_LEN),
    .DEFAULT_CODE (DEF_CODE),
    .CLK_HZ       (CLK_HZ),
    .ERR_SEC      (ERR_SEC),
    .OPEN_SEC     (OPEN_SEC),
    .MAX_FAILS    (MAX_FAILS),
    .LOCKOUT_SEC  (LOCKOUT_SEC)
  ) dut (
    .clk            (clk),
    .rstn           (rstn),
    .btn_i          (btn),
`ifdef SAFECRACK_REPROGRAM_EN
    .prog_n_i       (prog_n),
`endif
    .led_progress_o (led_progress),
    .led_r_o        (led_r),
    .led_lock_o     (led_lock),
    .fail_cnt_o     (fail_cnt)
  );

  typedef struct packed {
    logic [CODE_LEN-1:0] prog;
    logic                r;
    logic                lock;
    logic [FW-1:0]       fails;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_vec  = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: lock modes with dwell counted in whole cycles remaining.
  typedef enum {M_ENTRY, M_ERROR, M_OPEN, M_LOCK, M_PROG} mmode_t;
  mmode_t m_mode;
  int     m_idx, m_fails, m_left;
  int     m_code[CODE_LEN];
  int     m_shadow[CODE_LEN];
  logic [NUM_BTN-1:0] h_btn[$];
  logic               h_prog[$];

  task automatic model_step(input logic [NUM_BTN-1:0] b, input logic p, input bit rst);
    logic [NUM_BTN-1:0] newp;
    logic               prog_hit;
    int                 v;
    exp_t               e;
    newp     = '0;
    prog_hit = 1'b0;
    v        = 0;
    if (rst) begin
      m_mode  = M_ENTRY;
      m_idx   = 0;
      m_fails = 0;
      m_left  = 0;
      for (int i = 0; i < CODE_LEN; i++) m_code[i] = int'(DEF_CODE[2*i +: 2]);
      h_btn.delete();
      h_prog.delete();
    end else begin
      // A press is a released->pressed change between two post-reset samples, seen two cycles later.
      h_btn.push_back(~b);
      h_prog.push_back(~p);
      if (h_btn.size() > 4) begin
        h_btn.delete(0);
        h_prog.delete(0);
      end
      if (h_btn.size() == 4) begin
        newp     = h_btn[1] & ~h_btn[0];
        prog_hit = h_prog[1] & ~h_prog[0];
      end
      for (int i = 0; i < NUM_BTN; i++) if (newp[i]) v = i;
      case (m_mode)
        M_ENTRY: if (newp != '0) begin
          if ($countones(newp) == 1 && v == m_code[m_idx]) begin
            if (m_idx == CODE_LEN - 1) begin
              m_mode = M_OPEN; m_left = OPEN_SEC * CLK_HZ; m_idx = 0; m_fails = 0;
            end else m_idx++;
          end else begin
            m_fails++;
            m_idx = 0;
            if (m_fails == MAX_FAILS) begin m_mode = M_LOCK; m_left = LOCKOUT_SEC * CLK_HZ; end
            else begin m_mode = M_ERROR; m_left = ERR_SEC * CLK_HZ; end
          end
        end
        M_ERROR, M_OPEN, M_LOCK: begin
          m_left--;
          if (m_left == 0) begin
            if (m_mode == M_LOCK) m_fails = 0;
            m_mode = M_ENTRY;
            m_idx  = 0;
          end else if (m_mode == M_OPEN && prog_hit) begin
`ifdef SAFECRACK_REPROGRAM_EN
            m_mode = M_PROG; m_idx = 0; m_left = OPEN_SEC * CLK_HZ;
`endif
          end
        end
        M_PROG: begin
          if (newp != '0) begin
            if ($countones(newp) == 1) begin
              m_shadow[m_idx] = v;
              m_idx++;
              m_left = OPEN_SEC * CLK_HZ;
              if (m_idx == CODE_LEN) begin
                for (int i = 0; i < CODE_LEN; i++) m_code[i] = m_shadow[i];
                m_mode = M_ENTRY; m_idx = 0;
              end
            end else begin
              m_mode = M_ENTRY; m_idx = 0;
            end
          end else begin
            m_left--;
            if (m_left == 0) begin m_mode = M_ENTRY; m_idx = 0; end
          end
        end
        default: ;
      endcase
    end
    e.fails = FW'(m_fails);
    e.r     = (m_mode == M_ERROR);
    e.lock  = (m_mode == M_LOCK);
    case (m_mode)
      M_ENTRY: e.prog = CODE_LEN'((1 << (m_idx + 1)) - 1);
      M_OPEN:  e.prog = '1;
      M_PROG:  e.prog = CODE_LEN'((1 << m_idx) - 1);
      default: e.prog = '0;
    endcase
    sb.push_back(e);
  endtask

  // Monitor: the DUT presents its registered outputs every cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        mon_e = sb.pop_front();
        check("led_progress", 32'(led_progress), 32'(mon_e.prog));
        check("led_r",        32'(led_r),        32'(mon_e.r));
        check("led_lock",     32'(led_lock),     32'(mon_e.lock));
        check("fail_cnt",     32'(fail_cnt),     32'(mon_e.fails));
      end
    end
  end

  task automatic cycle(input logic [NUM_BTN-1:0] b, input logic p, input bit rst);
    @(negedge clk);
    #1;
    btn    = b;
    prog_n = p;
    rstn   = !rst;
    if (rst) begin
      #1;
      check("rst_progress", 32'(led_progress), 32'd1);
      check("rst_led_r",    32'(led_r),        32'd0);
      check("rst_led_lock", 32'(led_lock),     32'd0);
      check("rst_fail_cnt", 32'(fail_cnt),     32'd0);
    end
    @(posedge clk);
    model_step(b, p, rst);
  endtask

  task automatic idle(input int n);
    repeat (n) cycle('1, 1'b1, 1'b0);
  endtask

  task automatic press_mask(input logic [NUM_BTN-1:0] pm, input int hold, input int gap);
    repeat (hold) cycle(~pm, 1'b1, 1'b0);
    idle(gap);
  endtask

  task automatic press(input int b);
    press_mask(NUM_BTN'(1 << b), 2, 2);
  endtask

  task automatic enter(input int d0, input int d1, input int d2, input int d3);
    press(d0); press(d1); press(d2); press(d3);
  endtask

  task automatic prog_pulse();
    repeat (2) cycle('1, 1'b0, 1'b0);
    idle(2);
  endtask

  initial begin
    rstn = 1'b0;
    repeat (2) cycle('1, 1'b1, 1'b1);
    idle(4);

    // Correct code, full unlock dwell.
    enter(0, 1, 2, 3);
    idle(55);

    // Wrong second digit, presses during ERROR ignored.
    press(0); press(2);
    press(1); press(3);
    idle(35);

    // Two more failures reach lockout; presses inside lockout ignored.
    press(3); idle(35);
    press(1);
    press(0); press(2);
    idle(305);

    // Simultaneous presses count as a wrong press.
    press(0);
    press_mask(4'b0110, 2, 2);
    idle(35);

    // Button held through reset release never registers.
    cycle(4'b1110, 1'b1, 1'b1);
    repeat (8) cycle(4'b1110, 1'b1, 1'b0);
    idle(3);
    press(0); idle(4);
    press(3); idle(35);

    // Reset mid-unlock and mid-lockout, default code still works.
    enter(0, 1, 2, 3);
    idle(10);
    cycle('1, 1'b1, 1'b1);
    idle(4);
    repeat (3) begin press(2); idle(35); end
    idle(60);
    cycle('1, 1'b1, 1'b1);
    idle(4);
    enter(0, 1, 2, 3);
    idle(55);

`ifdef SAFECRACK_REPROGRAM_EN
    enter(0, 1, 2, 3);
    idle(3);
    prog_pulse();
    enter(3, 3, 1, 0);
    idle(4);
    press(0); idle(35);
    enter(3, 3, 1, 0);
    idle(3);
    prog_pulse();
    idle(55);
    enter(3, 3, 1, 0);
    idle(3);
    prog_pulse();
    press(1);
    press_mask(4'b1001, 2, 2);
    idle(60);
    enter(3, 3, 1, 0);
    idle(55);
`endif

    for (int it = 0; it < 250; it++) begin
      int r;
      int b;
      logic [NUM_BTN-1:0] mk;
      r = $urandom_range(0, 99);
      if (r < 3) begin
        cycle('1, 1'b1, 1'b1);
        idle($urandom_range(0, 5));
      end else if (r < 13) begin
        mk = NUM_BTN'($urandom_range(0, 15));
        while ($countones(mk) < 2) mk = NUM_BTN'($urandom_range(0, 15));
        press_mask(mk, $urandom_range(1, 3), $urandom_range(1, 3));
      end else if (r < 20) begin
        idle($urandom_range(0, 60));
      end else if (r < 26) begin
        prog_pulse();
      end else begin
        if ((m_mode == M_ENTRY || m_mode == M_PROG) && $urandom_range(0, 99) < 70)
          b = m_code[m_idx % CODE_LEN];
        else
          b = $urandom_range(0, NUM_BTN - 1);
        press_mask(NUM_BTN'(1 << b), $urandom_range(1, 3), $urandom_range(1, 3));
      end
    end

    idle(2);
    @(negedge clk);
    #2;
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
